// File: rtl/seq_detector_core.sv
// Serial pattern detector on the board clock. The divider's slow clock is
// treated as data: synchronised, edge-detected, and used to sample one din bit.
module seq_detector_core #(
  parameter int               PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8
) (
  input  logic               CCLK,
  input  logic               reset,
  input  logic               clk_div,
  input  logic               din,
  output logic               sample_tick,
  output logic               detect_pulse,
  output logic               detect_led,
  output logic [CNT_W-1:0]   match_count,
  output logic [PAT_LEN-1:0] history
);

  localparam int             FW   = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0]  FULL = FW'(PAT_LEN);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_HIT} state_t;

  state_t               state, state_d;
  logic [1:0]           clk_sync, din_sync, sync_vld;
  logic                 prev, armed, rise, cmp_pend, led_q;
  logic [FW-1:0]        fill, fill_next;
  logic [PAT_LEN-1:0]   hist_next;
  logic                 will_match;

  // sync_vld marks when clk_sync[1] holds a post-reset sample, so a slow clock
  // that is high at reset release is not mistaken for a low phase.
  always_ff @(posedge CCLK) begin
    if (reset) begin
      clk_sync <= '0;
      din_sync <= '0;
      sync_vld <= '0;
      prev     <= 1'b0;
      armed    <= 1'b0;
      cmp_pend <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], clk_div};
      din_sync <= {din_sync[0], din};
      sync_vld <= {sync_vld[0], 1'b1};
      prev     <= clk_sync[1];
      armed    <= armed | (sync_vld[1] & ~clk_sync[1]);
      cmp_pend <= rise;
    end
  end

  assign rise        = clk_sync[1] & ~prev & armed;
  assign sample_tick = rise;
  assign hist_next   = {history[PAT_LEN-2:0], din_sync[1]};
  assign fill_next   = (fill == FULL) ? FULL : fill + 1'b1;
  // Lets the LED stay lit across back-to-back matches instead of blinking off.
  assign will_match  = (fill_next == FULL) && (hist_next == PATTERN) &&
                       ((state == S_RUN) || (state == S_FILL));

  always_ff @(posedge CCLK) begin
    if (reset) begin
      history <= '0;
      fill    <= '0;
    end else if ((state == S_HIT) && !OVERLAP) begin
      history <= '0;
      fill    <= '0;
    end else if (rise) begin
      history <= hist_next;
      fill    <= fill_next;
    end
  end

  always_ff @(posedge CCLK) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d      = state;
    detect_pulse = 1'b0;
    case (state)
      S_IDLE: if (armed) state_d = S_FILL;
      S_FILL: if (rise && (fill_next == FULL)) state_d = S_RUN;
      S_RUN:  if (cmp_pend && (history == PATTERN)) state_d = S_HIT;
      S_HIT: begin
        detect_pulse = 1'b1;
        state_d      = OVERLAP ? S_RUN : S_FILL;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CCLK) begin
    if (reset) begin
      led_q       <= 1'b0;
      match_count <= '0;
    end else begin
      if (state == S_HIT)  led_q <= 1'b1;
      else if (rise)       led_q <= will_match;
      if ((state == S_HIT) && (match_count != '1))
        match_count <= match_count + 1'b1;
    end
  end

  assign detect_led = led_q | (state == S_HIT);

endmodule

// File: tb/tb_seq_detector_core.sv
// Directed bench: three detector variants driven by an 8-CCLK slow-clock
// stand-in, checked against hand-computed history/count/pulse tables.
module tb_seq_detector_core;

  logic CCLK = 1'b0;
  logic reset, clk_div, din;

  logic       tick_a, pulse_a, led_a, tick_b, pulse_b, led_b, tick_c, pulse_c, led_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;
  logic [3:0] hist_a, hist_b, hist_c;

  seq_detector_core #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) dut_a (
    .CCLK(CCLK), .reset(reset), .clk_div(clk_div), .din(din),
    .sample_tick(tick_a), .detect_pulse(pulse_a), .detect_led(led_a),
    .match_count(cnt_a), .history(hist_a));

  seq_detector_core #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) dut_b (
    .CCLK(CCLK), .reset(reset), .clk_div(clk_div), .din(din),
    .sample_tick(tick_b), .detect_pulse(pulse_b), .detect_led(led_b),
    .match_count(cnt_b), .history(hist_b));

  seq_detector_core #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) dut_c (
    .CCLK(CCLK), .reset(reset), .clk_div(clk_div), .din(din),
    .sample_tick(tick_c), .detect_pulse(pulse_c), .detect_led(led_c),
    .match_count(cnt_c), .history(hist_c));

  always #5 CCLK = ~CCLK;

  int n_vec = 0, n_err = 0;
  int nt_a = 0, np_a = 0, np_b = 0, np_c = 0;

  always @(negedge CCLK) begin
    if (tick_a)  nt_a++;
    if (pulse_a) np_a++;
    if (pulse_b) np_b++;
    if (pulse_c) np_c++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CCLK);
    #1;
  endtask

  task automatic do_reset(input logic cd);
    reset = 1'b1; clk_div = cd; din = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    if (!cd) repeat (4) step();
  endtask

  // One slow-clock period: 4 CCLK high (din presented with the edge), 4 low.
  task automatic send_bit(input logic b);
    clk_div = 1'b1; din = b;
    repeat (4) step();
    clk_div = 1'b0;
    repeat (4) step();
  endtask

  typedef struct {
    logic       d;
    logic       pa;
    logic [7:0] ca;
    logic [3:0] ha;
    logic       pb;
    logic [7:0] cb;
    logic [3:0] hb;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int t0, pa0, pb0, pc0;
    reset = 1'b1; clk_div = 1'b0; din = 1'b0;

    // Stream 1,0,1,1,0,1,1: overlapping vs history-clearing variants
    tbl[0] = '{1'b1, 1'b0, 8'd0, 4'b0001, 1'b0, 8'd0, 4'b0001};
    tbl[1] = '{1'b0, 1'b0, 8'd0, 4'b0010, 1'b0, 8'd0, 4'b0010};
    tbl[2] = '{1'b1, 1'b0, 8'd0, 4'b0101, 1'b0, 8'd0, 4'b0101};
    tbl[3] = '{1'b1, 1'b1, 8'd1, 4'b1011, 1'b1, 8'd1, 4'b0000};
    tbl[4] = '{1'b0, 1'b0, 8'd1, 4'b0110, 1'b0, 8'd1, 4'b0000};
    tbl[5] = '{1'b1, 1'b0, 8'd1, 4'b1101, 1'b0, 8'd1, 4'b0001};
    tbl[6] = '{1'b1, 1'b1, 8'd2, 4'b1011, 1'b0, 8'd1, 4'b0011};

    do_reset(1'b0);
    chk("reset_cnt_a",  32'(cnt_a), 0);
    chk("reset_hist_a", 32'(hist_a), 0);
    chk("reset_led_a",  32'(led_a), 0);
    chk("reset_pulse_a", 32'(pulse_a), 0);

    for (int i = 0; i < 7; i++) begin
      t0 = nt_a; pa0 = np_a; pb0 = np_b;
      send_bit(tbl[i].d);
      chk($sformatf("v%0d_tick", i),   32'(nt_a - t0), 1);
      chk($sformatf("v%0d_pulse_a", i), 32'(np_a - pa0), 32'(tbl[i].pa));
      chk($sformatf("v%0d_cnt_a", i),  32'(cnt_a), 32'(tbl[i].ca));
      chk($sformatf("v%0d_hist_a", i), 32'(hist_a), 32'(tbl[i].ha));
      chk($sformatf("v%0d_led_a", i),  32'(led_a), 32'(tbl[i].pa));
      chk($sformatf("v%0d_pulse_b", i), 32'(np_b - pb0), 32'(tbl[i].pb));
      chk($sformatf("v%0d_cnt_b", i),  32'(cnt_b), 32'(tbl[i].cb));
      chk($sformatf("v%0d_hist_b", i), 32'(hist_b), 32'(tbl[i].hb));
      chk($sformatf("v%0d_led_b", i),  32'(led_b), 32'(tbl[i].pb));
    end

    // Cycle-level latency: 1,0,1 then the final 1 driven by hand
    do_reset(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    clk_div = 1'b1; din = 1'b1;
    step();  // edge E
    chk("lat_tick_E",   32'(tick_a), 0);
    chk("lat_hist_E",   32'(hist_a), 32'(4'b0101));
    step();  // E+1
    chk("lat_tick_E1",  32'(tick_a), 1);
    chk("lat_hist_E1",  32'(hist_a), 32'(4'b0101));
    step();  // E+2
    chk("lat_tick_E2",  32'(tick_a), 0);
    chk("lat_hist_E2",  32'(hist_a), 32'(4'b1011));
    chk("lat_pulse_E2", 32'(pulse_a), 0);
    step();  // E+3
    chk("lat_pulse_E3", 32'(pulse_a), 1);
    chk("lat_led_E3",   32'(led_a), 1);
    step();  // E+4
    chk("lat_pulse_E4", 32'(pulse_a), 0);
    chk("lat_cnt_E4",   32'(cnt_a), 1);
    chk("lat_led_E4",   32'(led_a), 1);
    clk_div = 1'b0; din = 1'b0;
    repeat (4) step();

    // Slow clock high through reset release must not produce a sample
    do_reset(1'b1);
    t0 = nt_a;
    for (int i = 0; i < 10; i++) begin
      din = i[0];
      step();
    end
    chk("hold_no_tick", 32'(nt_a - t0), 0);
    chk("hold_hist",    32'(hist_a), 0);
    clk_div = 1'b0; din = 1'b0;
    repeat (4) step();
    t0 = nt_a;
    send_bit(1'b1);
    chk("hold_first_tick", 32'(nt_a - t0), 1);
    chk("hold_first_hist", 32'(hist_a), 32'(4'b0001));

    // Saturating 2-bit counter over five overlapping matches
    do_reset(1'b0);
    pc0 = np_c;
    for (int r = 0; r < 5; r++) begin
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      chk($sformatf("sat_cnt_c_r%0d", r), 32'(cnt_c), (r < 2) ? r + 1 : 3);
    end
    chk("sat_pulses_c", 32'(np_c - pc0), 5);
    chk("sat_cnt_a",    32'(cnt_a), 5);

    // Reset mid-pattern, then a lone 1 must not complete the old 101
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    reset = 1'b1;
    step();
    chk("mid_rst_tick",  32'(tick_a), 0);
    chk("mid_rst_pulse", 32'(pulse_a), 0);
    chk("mid_rst_led",   32'(led_a), 0);
    chk("mid_rst_cnt",   32'(cnt_a), 0);
    chk("mid_rst_hist",  32'(hist_a), 0);
    chk("mid_rst_cnt_c", 32'(cnt_c), 0);
    reset = 1'b0;
    repeat (4) step();
    pa0 = np_a;
    send_bit(1'b1);
    chk("mid_lone_pulse", 32'(np_a - pa0), 0);
    chk("mid_lone_hist",  32'(hist_a), 32'(4'b0001));
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    chk("mid_partial_pulse", 32'(np_a - pa0), 0);
    send_bit(1'b1);
    chk("mid_full_pulse", 32'(np_a - pa0), 1);
    chk("mid_full_cnt",   32'(cnt_a), 1);
    chk("mid_full_hist",  32'(hist_a), 32'(4'b1011));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
